// File: rtl/fetch_responder.sv
// Fetch-side responder: accepts PC requests, reads 1-cycle instruction memory, returns words in order.
// Optional misaligned-fetch faulting is enabled by defining FETCH_RESPONDER_MISALIGN_CHECK_EN.
module fetch_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      flush,
  output logic                      mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INSTR_WIDTH-1:0]    mem_rdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [INSTR_WIDTH-1:0]    rsp_instr,
  output logic [ADDR_WIDTH-1:0]     rsp_addr,
  output logic                      rsp_fault
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_q_addr  [QUEUE_DEPTH];
  logic                   r_q_fault [QUEUE_DEPTH];

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_inflight;
  logic [ADDR_WIDTH-1:0]  r_inflight_addr;
  logic                   r_inflight_fault;

  logic                   w_misalign;
  logic [CNT_W:0]         w_occupancy;
  logic                   w_accept;
  logic                   w_pop;

`ifdef FETCH_RESPONDER_MISALIGN_CHECK_EN
  assign w_misalign = (req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // The in-flight read already owns a queue slot, so it counts against capacity.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign req_ready   = !reset && !flush && (w_occupancy < (CNT_W+1)'(QUEUE_DEPTH));
  assign w_accept    = req_valid && req_ready;

  assign mem_en   = w_accept && !w_misalign;
  assign mem_addr = req_addr[MEM_ADDR_WIDTH+1:2];

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready && !flush;
  assign rsp_instr = r_q_instr[r_rd_ptr];
  assign rsp_addr  = r_q_addr[r_rd_ptr];
  // Fault flag is forced low on an empty head so reset leaves it deasserted.
  assign rsp_fault = rsp_valid && r_q_fault[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_inflight       <= 1'b0;
      r_inflight_addr  <= '0;
      r_inflight_fault <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_addr  <= req_addr;
        r_inflight_fault <= w_misalign;
      end

      if (r_inflight) begin
        r_q_instr[r_wr_ptr] <= r_inflight_fault ? '0 : mem_rdata;
        r_q_addr[r_wr_ptr]  <= r_inflight_addr;
        r_q_fault[r_wr_ptr] <= r_inflight_fault;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/fetch_responder.md
# fetch_responder

Instruction-side responder for the Fetch stage. It accepts fetch address requests from `program_counter` over a valid/ready handshake and issues reads to a one-cycle-latency synchronous instruction memory. Returned instruction words are buffered in an in-order response queue and presented to Decode with their fetch address. A `flush` input discards everything queued and in flight when a redirect occurs.

## Interface
- `ADDR_WIDTH`, 32, byte address width of fetch requests
- `INSTR_WIDTH`, 32, instruction word width
- `MEM_ADDR_WIDTH`, 10, word-address width driven to instruction memory
- `QUEUE_DEPTH`, 4, response queue entries; power of two, ≥2

- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  PC presents a fetch address
- `req_ready`  out  1  responder accepts this cycle
- `req_addr`  in  ADDR_WIDTH  byte fetch address
- `flush`  in  1  redirect: drop queued and in-flight fetches
- `mem_en`  out  1  memory read enable
- `mem_addr`  out  MEM_ADDR_WIDTH  word address = `req_addr[MEM_ADDR_WIDTH+1:2]`
- `mem_rdata`  in  INSTR_WIDTH  read data, valid the cycle after `mem_en`
- `rsp_valid`  out  1  queue head valid
- `rsp_ready`  in  1  Decode consumes head
- `rsp_instr`  out  INSTR_WIDTH  instruction word at head
- `rsp_addr`  out  ADDR_WIDTH  fetch address of head
- `rsp_fault`  out  1  head is a misaligned fetch (see Configuration)

## Operation
- State: queue (storage, rd/wr pointers, `count`), `inflight` flag, `inflight_addr`, `inflight_fault` registers.
- `req_ready = !reset && !flush && (count + inflight) < QUEUE_DEPTH`. Independent of `rsp_ready`; a same-cycle pop does not free a slot for that cycle's accept.
- Accept = `req_valid && req_ready`. On accept, combinationally `mem_en=1`, `mem_addr` from `req_addr`; next edge sets `inflight=1` and captures address and fault.
- No accept: `mem_en=0`; `inflight` clears next edge.
- When `inflight=1`, `mem_rdata` with `inflight_addr`/`inflight_fault` is written into the queue at the tail on that edge.
- Pop = `rsp_valid && rsp_ready`; head advances on the edge. Push and pop in the same cycle leave `count` unchanged.
- `rsp_valid = (count != 0)`; head outputs are driven from storage at the read pointer.
- `flush`: on the edge, `count`, pointers and `inflight` are cleared; in-flight data is not written; no accept in the flush cycle. A pop in the flush cycle is ignored.
- Requests are returned strictly in acceptance order; no reordering or drops except on flush/reset.
- `count` width is `$clog2(QUEUE_DEPTH)+1`; pointers wrap modulo `QUEUE_DEPTH`.

## Timing
- Reset (asserted cycles): `req_ready=0`, `mem_en=0`, `rsp_valid=0`, `rsp_fault=0`, `count=0`, `inflight=0`. `rsp_instr`/`rsp_addr` are don't-care while `rsp_valid=0`.
- First cycle after reset deassertion: `req_ready=1`.
- Latency: accept in cycle N → `rsp_valid=1` in cycle N+2 (queue previously empty). No bypass path.
- Sustained throughput: 1 fetch/cycle while Decode pops every cycle.
- Full: `count + inflight == QUEUE_DEPTH` holds `req_ready=0` until a pop edge.
- Reset mid-operation: overrides flush and any handshake; all state is cleared on that edge.

## Configuration
- `FETCH_RESPONDER_MISALIGN_CHECK_EN` defined: a request with `req_addr[1:0] != 0` is accepted, but `mem_en` stays 0. The entry is queued in order with `rsp_fault=1` and `rsp_instr=0`.
- Undefined: `req_addr[1:0]` is ignored, every accept reads memory, and `rsp_fault` is tied to 0.

## Test plan
- Reset, then requests 0x0,0x4,0x8 on consecutive cycles with `rsp_ready=1` → `mem_addr` 0,1,2. `rsp_valid` rises 2 cycles after the first accept; the bench sees `rsp_addr` 0x0,0x4,0x8 with matching memory words, one per cycle.
- Hold `rsp_ready=0` and stream requests with QUEUE_DEPTH=4 → exactly 4 accepts, then `req_ready=0`. Release `rsp_ready` → 4 in-order responses, and `req_ready` returns the cycle after the first pop.
- Steady state with push and pop in the same cycle at `count=2` → `count` stays 2 and no entry is lost or duplicated.
- Flush while `count=3` and `inflight=1` → next cycle `rsp_valid=0`. A new request 0x100 then produces only the 0x100 response; stale data never appears.
- Assert `reset` with a full queue → `rsp_valid=0`, `req_ready=0` during reset, and `req_ready=1` the first cycle after release.
- With the macro defined, request 0x6 between 0x4 and 0x8 → responses arrive in order 0x4, 0x6 (`rsp_fault=1`, instr 0, no `mem_en`), 0x8. With the macro undefined, 0x6 reads word 1 and `rsp_fault=0`.
